// File: rtl/regfile_arbiter.sv
// regfile_arbiter: two-requester sequencer for a 1R/1W register file.
// Reads and writes have independent round-robin arbiters. A read is deferred when the write in the same cycle targets the same address.
module regfile_arbiter #(
    parameter int  WIDTH = 32,
    parameter int  N     = 4,
    localparam int AW    = $clog2(N)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [1:0]            req_we,
    input  logic [1:0][AW-1:0]    req_addr,
    input  logic [1:0][WIDTH-1:0] req_wdata,
    output logic [1:0]            rsp_valid,
    output logic [WIDTH-1:0]      rsp_rdata,
    output logic                  rf_read_en,
    output logic [AW-1:0]         rf_read_addr,
    output logic                  rf_write_en,
    output logic [AW-1:0]         rf_write_addr,
    output logic [WIDTH-1:0]      rf_data_in,
    input  logic [WIDTH-1:0]      rf_data_out
);

    logic       r_wr_last;
    logic       r_rd_last;
    logic [1:0] r_rsp_pend;

    logic [1:0] w_wr_gnt;
    logic [1:0] w_rd_pick;
    logic [1:0] w_rd_gnt;
    logic       w_wr_idx;
    logic       w_rd_idx;
    logic       w_conflict;

    // With both candidates present, the one that did not win last time wins now.
    function automatic logic [1:0] rr_pick(input logic [1:0] cand, input logic last);
        if (cand == 2'b11) rr_pick = last ? 2'b01 : 2'b10;
        else               rr_pick = cand;
    endfunction

    always_comb begin
        // NOTE: defaults first on every combinational output so no path can infer a latch.
        w_wr_gnt  = 2'b00;
        w_rd_pick = 2'b00;
        if (rst_n) begin
            w_wr_gnt  = rr_pick(req_valid & req_we, r_wr_last);
            w_rd_pick = rr_pick(req_valid & ~req_we, r_rd_last);
        end
    end

    assign w_wr_idx   = w_wr_gnt[1];
    assign w_rd_idx   = w_rd_pick[1];
    assign w_conflict = (|w_wr_gnt) && (|w_rd_pick) &&
                        (req_addr[w_wr_idx] == req_addr[w_rd_idx]);
    assign w_rd_gnt   = w_conflict ? 2'b00 : w_rd_pick;

    assign req_ready     = w_wr_gnt | w_rd_gnt;
    assign rf_write_en   = |w_wr_gnt;
    assign rf_write_addr = rf_write_en ? req_addr[w_wr_idx] : '0;
    assign rf_data_in    = rf_write_en ? req_wdata[w_wr_idx] : '0;
    assign rf_read_en    = |w_rd_gnt;
    assign rf_read_addr  = rf_read_en ? req_addr[w_rd_idx] : '0;

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            r_rsp_pend <= 2'b00;
            r_wr_last  <= 1'b1;
            r_rd_last  <= 1'b1;
        end else begin
            r_rsp_pend <= w_rd_gnt;
            if (rf_write_en) r_wr_last <= w_wr_idx;
            if (rf_read_en)  r_rd_last <= w_rd_idx;
        end
    end

    assign rsp_valid = r_rsp_pend;
    assign rsp_rdata = (|r_rsp_pend) ? rf_data_out : '0;

endmodule

// File: tb/tb_regfile_arbiter.sv
// tb_regfile_arbiter: directed plus randomized stimulus against a behavioural model.
// The register file is modelled here; expected values come from a shadow memory and priority holders.
module tb_regfile_arbiter;
    localparam int WIDTH = 32;
    localparam int N     = 4;
    localparam int AW    = $clog2(N);

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [1:0]            req_valid;
    logic [1:0]            req_ready;
    logic [1:0]            req_we;
    logic [1:0][AW-1:0]    req_addr;
    logic [1:0][WIDTH-1:0] req_wdata;
    logic [1:0]            rsp_valid;
    logic [WIDTH-1:0]      rsp_rdata;
    logic                  rf_read_en;
    logic [AW-1:0]         rf_read_addr;
    logic                  rf_write_en;
    logic [AW-1:0]         rf_write_addr;
    logic [WIDTH-1:0]      rf_data_in;
    logic [WIDTH-1:0]      rf_data_out;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: tie-break holder per command type, shadow contents, next response.
    logic [WIDTH-1:0] m_mem [N];
    int               m_wr_prio;
    int               m_rd_prio;
    logic [1:0]       m_rsp_mask;
    logic [WIDTH-1:0] m_rsp_data;
    logic [1:0]       m_acc;

    logic [WIDTH-1:0] rf_mem [N];

    regfile_arbiter #(.WIDTH(WIDTH), .N(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rf_read_en(rf_read_en), .rf_read_addr(rf_read_addr),
        .rf_write_en(rf_write_en), .rf_write_addr(rf_write_addr),
        .rf_data_in(rf_data_in), .rf_data_out(rf_data_out)
    );

    always #5 clk = ~clk;

    // Behavioural register file: registered read, contents cleared on reset.
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) rf_mem[i] <= '0;
            rf_data_out <= '0;
        end else begin
            if (rf_write_en) rf_mem[rf_write_addr] <= rf_data_in;
            if (rf_read_en)  rf_data_out <= rf_mem[rf_read_addr];
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int winner(input logic [1:0] cand, input int prio);
        if (cand == 2'b11) return prio;
        if (cand[0])       return 0;
        if (cand[1])       return 1;
        return -1;
    endfunction

    task automatic drive(input logic [1:0] v, input logic [1:0] we,
                         input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                         input logic [WIDTH-1:0] d0, input logic [WIDTH-1:0] d1);
        req_valid    = v;
        req_we       = we;
        req_addr[0]  = a0;
        req_addr[1]  = a1;
        req_wdata[0] = d0;
        req_wdata[1] = d1;
    endtask

    // One clock cycle: compare outputs mid-cycle, advance the model, return just after the edge.
    task automatic cycle();
        int               ww;
        int               rw;
        logic [1:0]       exp_ready;
        logic [WIDTH-1:0] rd_val;
        @(negedge clk);
        check("rsp_valid", rsp_valid, m_rsp_mask);
        check("rsp_rdata", rsp_rdata, m_rsp_data);
        if (!rst_n) begin
            check("rst_ready", req_ready, 2'b00);
            check("rst_rd_en", rf_read_en, 1'b0);
            check("rst_wr_en", rf_write_en, 1'b0);
            check("rst_wr_addr", rf_write_addr, '0);
            check("rst_wr_data", rf_data_in, '0);
            check("rst_rd_addr", rf_read_addr, '0);
            for (int i = 0; i < N; i++) m_mem[i] = '0;
            m_wr_prio  = 0;
            m_rd_prio  = 0;
            m_rsp_mask = 2'b00;
            m_rsp_data = '0;
            m_acc      = 2'b00;
        end else begin
            ww = winner(req_valid & req_we, m_wr_prio);
            rw = winner(req_valid & ~req_we, m_rd_prio);
            if (ww >= 0 && rw >= 0 && req_addr[ww] == req_addr[rw]) rw = -1;
            exp_ready = 2'b00;
            if (ww >= 0) exp_ready[ww] = 1'b1;
            if (rw >= 0) exp_ready[rw] = 1'b1;
            check("req_ready", req_ready, exp_ready);
            check("wr_en", rf_write_en, ww >= 0);
            check("rd_en", rf_read_en, rw >= 0);
            check("wr_addr", rf_write_addr, (ww >= 0) ? req_addr[ww] : '0);
            check("wr_data", rf_data_in, (ww >= 0) ? req_wdata[ww] : '0);
            check("rd_addr", rf_read_addr, (rw >= 0) ? req_addr[rw] : '0);
            rd_val = (rw >= 0) ? m_mem[req_addr[rw]] : '0;
            if (ww >= 0) begin
                m_mem[req_addr[ww]] = req_wdata[ww];
                m_wr_prio = 1 - ww;
            end
            if (rw >= 0) begin
                m_rd_prio  = 1 - rw;
                m_rsp_mask = (rw == 0) ? 2'b01 : 2'b10;
            end else begin
                m_rsp_mask = 2'b00;
            end
            m_rsp_data = rd_val;
            m_acc      = exp_ready;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        drive(2'b11, 2'b01, 2'd2, 2'd0, 32'h1, 32'h2);
        @(posedge clk);
        #1;
        repeat (3) cycle();

        // Release: both write, requester 0 first; then read-after-write.
        rst_n = 1'b1;
        drive(2'b11, 2'b11, 2'd2, 2'd3, 32'hDEADBEEF, 32'h33);
        #1 check("first_grant", req_ready, 2'b01);
        cycle();
        drive(2'b11, 2'b10, 2'd2, 2'd3, 32'h0, 32'h33);
        #1 check("raw_ready", req_ready, 2'b11);
        cycle();
        check("raw_valid", rsp_valid, 2'b01);
        check("raw_data", rsp_rdata, 32'hDEADBEEF);

        // Write contention alternates, then read both back.
        drive(2'b11, 2'b11, 2'd1, 2'd3, 32'h11, 32'h33);
        for (int k = 0; k < 4; k++) begin
            #1 check("wr_contend", req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
            cycle();
        end
        drive(2'b01, 2'b00, 2'd1, 2'd0, 32'h0, 32'h0);
        cycle();
        check("rd1_valid", rsp_valid, 2'b01);
        check("rd1_data", rsp_rdata, 32'h11);
        drive(2'b10, 2'b00, 2'd0, 2'd3, 32'h0, 32'h0);
        cycle();
        check("rd3_valid", rsp_valid, 2'b10);
        check("rd3_data", rsp_rdata, 32'h33);

        // Parallel read and write to different addresses.
        drive(2'b01, 2'b01, 2'd0, 2'd0, 32'h5, 32'h0);
        cycle();
        drive(2'b11, 2'b01, 2'd1, 2'd0, 32'hA5A5A5A5, 32'h0);
        #1 check("par_ready", req_ready, 2'b11);
        cycle();
        check("par_valid", rsp_valid, 2'b10);
        check("par_data", rsp_rdata, 32'h5);

        // Same-address conflict defers the read by one cycle.
        drive(2'b11, 2'b01, 2'd2, 2'd2, 32'h12345678, 32'h0);
        #1 check("conf_ready0", req_ready, 2'b01);
        cycle();
        drive(2'b10, 2'b00, 2'd0, 2'd2, 32'h0, 32'h0);
        #1 check("conf_ready1", req_ready, 2'b10);
        cycle();
        check("conf_valid", rsp_valid, 2'b10);
        check("conf_data", rsp_rdata, 32'h12345678);

        // Reset lands on the edge after a read is accepted: no response survives.
        drive(2'b10, 2'b00, 2'd0, 2'd0, 32'h0, 32'h0);
        #1 check("rstrd_ready", req_ready, 2'b10);
        cycle();
        rst_n = 1'b0;
        drive(2'b00, 2'b00, 2'd0, 2'd0, 32'h0, 32'h0);
        cycle();
        check("rstrd_valid", rsp_valid, 2'b00);
        check("rstrd_data", rsp_rdata, 32'h0);
        cycle();
        rst_n = 1'b1;
        drive(2'b10, 2'b00, 2'd0, 2'd0, 32'h0, 32'h0);
        cycle();
        check("post_rst_valid", rsp_valid, 2'b10);
        check("post_rst_data", rsp_rdata, 32'h0);

        // Random traffic; a requester holds its command until accepted.
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (!rst_n || !req_valid[i] || m_acc[i]) begin
                    req_valid[i] = ($urandom_range(0, 3) != 0);
                    req_we[i]    = 1'($urandom_range(0, 1));
                    req_addr[i]  = AW'($urandom_range(0, N - 1));
                    req_wdata[i] = $urandom;
                end
            end
            rst_n = ($urandom_range(0, 49) != 0);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
